chunked_seq_adder: RTL and testbench
====================================

Name: chunked_seq_adder

Overview:
- Parametrised multi-cycle adder/subtractor. Successor to the fixed 64-bit cascaded adder.
- Adds or subtracts two WIDTH-bit operands one CHUNK-bit slice per clock. The carry is registered between slices, which trades latency for a short critical path.
- Valid/ready handshakes on input and output, so it plugs into the datapath/ALU pipeline without external sequencing.
- Reports carry/borrow and signed overflow.

Parameters:
- WIDTH, 64, operand/result width in bits.
- CHUNK, 16, bits processed per cycle. WIDTH must be an integer multiple of CHUNK.
- NCHUNK (localparam), WIDTH/CHUNK, number of slices (cycles) per operation.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands/mode valid
- in_ready  out  1  block can accept an operation
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- Cin  in  1  carry-in; used in add mode only
- sub  in  1  0 = A+B+Cin, 1 = A-B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- Sum  out  WIDTH  result
- Carry  out  1  carry-out (add) / not-borrow (sub)
- Overflow  out  1  signed two's-complement overflow

Interface note: one clock (clk); reset rst is synchronous and active-high.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; Sum=0, Carry=0, Overflow=0, out_valid=0; chunk index=0; internal operand/carry registers cleared.
  - in_ready=1 from the first cycle after reset.
  - Reset wins over every other input in the same cycle, including mid-CALC and DONE. Any in-flight operation is discarded and no result is emitted.
- States: IDLE, CALC, DONE.
- in_ready = (state==IDLE). out_valid = (state==DONE). Both are registered-state decodes with no combinational path from inputs.
- IDLE:
  - When in_valid&&in_ready at a clk edge, register A and B.
  - B is registered as ~B when sub=1.
  - Carry register is set to 1 when sub=1, else to Cin.
  - Clear Sum; set idx=0; go to CALC.
  - in_valid while not in IDLE is ignored; it is not queued.
- CALC, each cycle:
  - Compute {c,s} = A_slice[idx] + B_slice[idx] + carry_reg, CHUNK+1 bits wide.
  - Write s into Sum[idx*CHUNK +: CHUNK]; carry_reg <= c; idx <= idx+1.
  - On the edge processing idx==NCHUNK-1: Carry <= c, Overflow <= (a_msb==b_msb)&&(s_msb!=a_msb), using the effective (possibly inverted) B msb. Go to DONE.
- Latency: out_valid rises exactly NCHUNK cycles after the accepting edge (64/16 gives 4). The NCHUNK=1 degenerate case gives 1 cycle.
- DONE:
  - Sum, Carry and Overflow are held stable while out_valid=1 && out_ready=0, for any duration.
  - When out_ready=1, transfer completes at that edge and state goes to IDLE. in_ready=1 the next cycle.
  - Sum/Carry/Overflow keep their last values in IDLE and are only cleared when a new operation is accepted.
- Throughput: one operation per NCHUNK+2 cycles max (accept, NCHUNK calc, DONE handshake). No overlap of operations.
- Subtraction: Carry=1 means no borrow (A>=B unsigned). Cin is ignored when sub=1.
- Wrap-around: Sum is modulo 2^WIDTH; the carry out of the top slice appears only on Carry.
- Intermediate Sum slices may be observed during CALC. They are not valid until out_valid.

Test Plan:
- Add wrap, W=64/C=16: A=FFFF_FFFF_FFFF_FFFF, B=0, Cin=1, sub=0 -> Sum=0, Carry=1, Overflow=0. out_valid exactly 4 cycles after accept edge. Carry ripples through all 4 slices.
- Signed overflow: A=7FFF_FFFF_FFFF_FFFF, B=1, Cin=0 -> Sum=8000_0000_0000_0000, Carry=0, Overflow=1. Also A=B=8000_..._0000 -> Sum=0, Carry=1, Overflow=1.
- Subtract: A=5, B=7, sub=1, Cin=1 (must be ignored) -> Sum=FFFF_FFFF_FFFF_FFFE, Carry=0, Overflow=0. Also A=7, B=5 -> Sum=2, Carry=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 with new operands. Required: outputs constant, in_ready=0, new operands not captured. Raise out_ready -> IDLE next cycle, then the next operation is accepted.
- Reset mid-operation: assert rst for 1 cycle on the 2nd CALC cycle. Required: next cycle out_valid=0, in_ready=1, Sum=0, Carry=0, Overflow=0, and no result is ever emitted for the aborted operation.
- Parameter sweep with random operands vs. a golden model, 1000 operations each:
  - W=32/C=8 -> latency 4.
  - W=64/C=64 -> latency 1.
  - W=16/C=1 -> latency 16.
  - Sum, Carry and Overflow must match in every case.

Source files
------------

// File: rtl/chunked_seq_adder.sv
// -----------------------------------------------------------------------------
// chunked_seq_adder
//
// Multi-cycle adder/subtractor. Each operation takes WIDTH/CHUNK cycles: one
// CHUNK-bit slice is added per clock, and the slice carry is registered between
// slices, so the critical path is a single CHUNK-bit adder. Valid/ready
// handshakes on both sides; one operation is in flight at a time.
// WIDTH must be an integer multiple of CHUNK.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operands/mode valid
//   in_ready   block can accept an operation (state IDLE)
//   A, B       WIDTH-bit operands
//   Cin        carry-in, add mode only
//   sub        0: A+B+Cin, 1: A-B
//   out_valid  result valid (state DONE)
//   out_ready  consumer accepts the result
//   Sum        WIDTH-bit result, modulo 2^WIDTH
//   Carry      carry-out (add) / not-borrow (sub)
//   Overflow   signed two's-complement overflow
// -----------------------------------------------------------------------------
module chunked_seq_adder #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Carry,
   output logic             Overflow
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;          // effective B: already inverted for subtraction
   logic             carry_r;      // carry into the slice processed this cycle
   logic [IDX_W-1:0] idx_r;
   logic [CHUNK-1:0] a_slice_s;
   logic [CHUNK-1:0] b_slice_s;
   logic [CHUNK:0]   slice_sum_s;
   logic             last_s;

   // Current slice selection and the single CHUNK-bit adder
   always_comb begin
      a_slice_s   = a_r[idx_r*CHUNK +: CHUNK];
      b_slice_s   = b_r[idx_r*CHUNK +: CHUNK];
      slice_sum_s = {1'b0, a_slice_s} + {1'b0, b_slice_s} + {{CHUNK{1'b0}}, carry_r};
      last_s      = (idx_r == LAST_IDX);
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (in_valid) begin
               state_nxt_s = CALC;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         CALC: begin
            if (last_s) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = CALC;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = DONE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Handshake outputs are pure decodes of the state register
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_r)
         IDLE: begin
            in_ready  = 1'b1;
            out_valid = 1'b0;
         end
         DONE: begin
            in_ready  = 1'b0;
            out_valid = 1'b1;
         end
         default: begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
         end
      endcase
   end

   // Operand capture and slice-by-slice accumulation of the result
   always_ff @(posedge clk) begin
      if (rst) begin
         a_r      <= '0;
         b_r      <= '0;
         carry_r  <= 1'b0;
         idx_r    <= '0;
         Sum      <= '0;
         Carry    <= 1'b0;
         Overflow <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  a_r      <= A;
                  // Subtraction is A + ~B + 1; Cin has no effect in this mode.
                  b_r      <= sub ? ~B : B;
                  carry_r  <= sub ? 1'b1 : Cin;
                  idx_r    <= '0;
                  Sum      <= '0;
                  Carry    <= 1'b0;
                  Overflow <= 1'b0;
               end
            end
            CALC: begin
               Sum[idx_r*CHUNK +: CHUNK] <= slice_sum_s[CHUNK-1:0];
               carry_r                   <= slice_sum_s[CHUNK];
               if (last_s) begin
                  // The top slice holds the sign bits of both operands and the result.
                  Carry    <= slice_sum_s[CHUNK];
                  Overflow <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                              (slice_sum_s[CHUNK-1] != a_r[WIDTH-1]);
                  idx_r    <= '0;
               end else begin
                  idx_r    <= idx_r + IDX_W'(1);
               end
            end
            default: begin
               // DONE holds the result stable until the consumer takes it.
            end
         endcase
      end
   end

endmodule

// File: tb/tb_chunked_seq_adder.sv
// -----------------------------------------------------------------------------
// tb_chunked_seq_adder
//
// Self-checking bench for chunked_seq_adder. Four instances cover the
// configurations 64/16, 32/8, 64/64 and 16/1. Expected results come from a
// full-width arithmetic model and are queued when an operation is accepted,
// then popped and compared when out_valid appears.
// -----------------------------------------------------------------------------
module tb_chunked_seq_adder;

   typedef struct {
      logic [63:0] s;
      logic        c;
      logic        v;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] a_in = 64'd0;
   logic [63:0] b_in = 64'd0;
   logic        cin_in = 1'b0;
   logic        sub_in = 1'b0;
   logic [3:0]  iv = 4'd0;
   logic [3:0]  ordy = 4'd0;
   logic [3:0]  ir;
   logic [3:0]  ov;
   logic [3:0]  cy;
   logic [3:0]  vf;
   logic [63:0] s0;
   logic [31:0] s1;
   logic [63:0] s2;
   logic [15:0] s3;
   logic [63:0] sum_w [4];

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   assign sum_w[0] = s0;
   assign sum_w[1] = {32'd0, s1};
   assign sum_w[2] = s2;
   assign sum_w[3] = {48'd0, s3};

   chunked_seq_adder #(.WIDTH(64), .CHUNK(16)) u_dut0 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
      .A(a_in), .B(b_in), .Cin(cin_in), .sub(sub_in),
      .out_valid(ov[0]), .out_ready(ordy[0]),
      .Sum(s0), .Carry(cy[0]), .Overflow(vf[0]));

   chunked_seq_adder #(.WIDTH(32), .CHUNK(8)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
      .A(a_in[31:0]), .B(b_in[31:0]), .Cin(cin_in), .sub(sub_in),
      .out_valid(ov[1]), .out_ready(ordy[1]),
      .Sum(s1), .Carry(cy[1]), .Overflow(vf[1]));

   chunked_seq_adder #(.WIDTH(64), .CHUNK(64)) u_dut2 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
      .A(a_in), .B(b_in), .Cin(cin_in), .sub(sub_in),
      .out_valid(ov[2]), .out_ready(ordy[2]),
      .Sum(s2), .Carry(cy[2]), .Overflow(vf[2]));

   chunked_seq_adder #(.WIDTH(16), .CHUNK(1)) u_dut3 (
      .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]),
      .A(a_in[15:0]), .B(b_in[15:0]), .Cin(cin_in), .sub(sub_in),
      .out_valid(ov[3]), .out_ready(ordy[3]),
      .Sum(s3), .Carry(cy[3]), .Overflow(vf[3]));

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Full-width reference: unsigned result/carry and signed range check.
   function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input logic cin, input logic sb);
      logic [65:0]        mask, ua, ub, full;
      logic signed [67:0] sa, sbv, res, maxv, minv;
      exp_t e;
      mask = (66'd1 << w) - 66'd1;
      ua   = {2'b00, a} & mask;
      ub   = {2'b00, b} & mask;
      if (sb) begin
         full = (ua - ub) & mask;
         e.c  = (ua >= ub);
      end else begin
         full = ua + ub + {65'd0, cin};
         e.c  = full[w];
         full = full & mask;
      end
      e.s  = full[63:0];
      sa   = $signed({2'b00, ua});
      sbv  = $signed({2'b00, ub});
      if (ua[w-1]) sa  = sa  - (68'sd1 <<< w);
      if (ub[w-1]) sbv = sbv - (68'sd1 <<< w);
      res  = sb ? (sa - sbv) : (sa + sbv + $signed({67'd0, cin}));
      maxv = (68'sd1 <<< (w - 1)) - 68'sd1;
      minv = -(68'sd1 <<< (w - 1));
      e.v  = (res > maxv) || (res < minv);
      return e;
   endfunction

   // One operation on instance k; hold>0 applies that many cycles of backpressure.
   task automatic run_op(input int k, input int w, input int lat,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic cin, input logic sb, input int hold);
      int   t;
      int   n;
      exp_t e;
      t = 0;
      while (!ir[k] && t < 50) begin
         @(negedge clk);
         t++;
      end
      check_eq("in_ready_before_op", 64'(ir[k]), 64'd1);
      a_in    = a;
      b_in    = b;
      cin_in  = cin;
      sub_in  = sb;
      iv[k]   = 1'b1;
      ordy[k] = (hold == 0);
      @(negedge clk);
      iv[k] = 1'b0;
      sb_q.push_back(model(w, a, b, cin, sb));
      n = 0;
      while (!ov[k] && n < lat + 50) begin
         @(negedge clk);
         n++;
      end
      check_eq("latency", 64'(n), 64'(lat));
      if (sb_q.size() == 0) begin
         check_eq("scoreboard_nonempty", 64'd0, 64'd1);
      end else begin
         e = sb_q.pop_front();
         check_eq("sum", sum_w[k], e.s);
         check_eq("carry", 64'(cy[k]), 64'(e.c));
         check_eq("overflow", 64'(vf[k]), 64'(e.v));
         for (int i = 0; i < hold; i++) begin
            a_in   = {$urandom, $urandom};
            b_in   = {$urandom, $urandom};
            cin_in = 1'($urandom_range(0, 1));
            sub_in = 1'($urandom_range(0, 1));
            iv[k]  = 1'b1;
            @(negedge clk);
            check_eq("bp_sum", sum_w[k], e.s);
            check_eq("bp_carry", 64'(cy[k]), 64'(e.c));
            check_eq("bp_overflow", 64'(vf[k]), 64'(e.v));
            check_eq("bp_in_ready", 64'(ir[k]), 64'd0);
            check_eq("bp_out_valid", 64'(ov[k]), 64'd1);
         end
         iv[k]   = 1'b0;
         ordy[k] = 1'b1;
         @(negedge clk);
         check_eq("post_out_valid", 64'(ov[k]), 64'd0);
         check_eq("post_in_ready", 64'(ir[k]), 64'd1);
         check_eq("post_sum_held", sum_w[k], e.s);
      end
   endtask

   // Reset asserted during the second CALC cycle of an operation on instance 0.
   task automatic reset_mid_op();
      logic saw;
      a_in    = 64'h0123_4567_89AB_CDEF;
      b_in    = 64'h1111_2222_3333_4444;
      cin_in  = 1'b1;
      sub_in  = 1'b0;
      ordy[0] = 1'b1;
      iv[0]   = 1'b1;
      @(negedge clk);          // accept edge passed, first CALC cycle
      iv[0] = 1'b0;
      @(negedge clk);          // second CALC cycle
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_eq("rst_out_valid", 64'(ov[0]), 64'd0);
      check_eq("rst_in_ready", 64'(ir[0]), 64'd1);
      check_eq("rst_sum", s0, 64'd0);
      check_eq("rst_carry", 64'(cy[0]), 64'd0);
      check_eq("rst_overflow", 64'(vf[0]), 64'd0);
      saw = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (ov[0]) saw = 1'b1;
      end
      check_eq("aborted_no_result", 64'(saw), 64'd0);
   endtask

   initial begin
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_eq("reset_in_ready", 64'(ir[0]), 64'd1);
      check_eq("reset_out_valid", 64'(ov[0]), 64'd0);
      check_eq("reset_sum", s0, 64'd0);
      check_eq("reset_carry", 64'(cy[0]), 64'd0);
      check_eq("reset_overflow", 64'(vf[0]), 64'd0);

      // Directed cases on the 64/16 instance
      run_op(0, 64, 4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 0);
      run_op(0, 64, 4, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0);
      run_op(0, 64, 4, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 0);
      run_op(0, 64, 4, 64'd5, 64'd7, 1'b1, 1'b1, 0);
      run_op(0, 64, 4, 64'd7, 64'd5, 1'b0, 1'b1, 0);
      run_op(0, 64, 4, 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0, 10);
      run_op(0, 64, 4, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0, 0);
      reset_mid_op();
      run_op(0, 64, 4, 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0002, 1'b0, 1'b1, 0);

      // Random sweeps on the other configurations
      for (int i = 0; i < 1000; i++)
         run_op(1, 32, 4, {$urandom, $urandom}, {$urandom, $urandom},
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      for (int i = 0; i < 1000; i++)
         run_op(2, 64, 1, {$urandom, $urandom}, {$urandom, $urandom},
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      for (int i = 0; i < 1000; i++)
         run_op(3, 16, 16, {$urandom, $urandom}, {$urandom, $urandom},
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
